// File: rtl/parity_scan_monitor.sv
// Parity scan monitor: counts parity mismatches over one address sweep and queues failing entries.
// Optional macro PARITY_RECHECK_EN enables an independent parity recheck driving checker_fault.
module parity_scan_monitor #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int FIFO_LOG2 = 2,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  input  logic              match,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [ADDR_W-1:0] rpt_addr,
  output logic [DATA_W-1:0] rpt_data,
  output logic [CNT_W-1:0]  err_count,
  output logic              overflow,
  output logic              seq_err,
  output logic              busy,
  output logic              done,
  output logic              checker_fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FIFO_LOG2:0] PTR_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};

  function automatic logic xor_reduce(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   expected_r;
  logic [CNT_W-1:0]    err_count_r;
  logic                overflow_r, seq_err_r, busy_r, done_r;
  logic [FIFO_LOG2:0]  wr_ptr_r, rd_ptr_r;
  logic [ENT_W-1:0]    mem_r [DEPTH];
  logic [ENT_W-1:0]    head_s;
  logic                fifo_empty_s, fifo_full_s;
  logic                sample_s, start_s, pop_s, push_req_s, push_s, drop_s;

  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[FIFO_LOG2] != rd_ptr_r[FIFO_LOG2]) &&
                        (wr_ptr_r[FIFO_LOG2-1:0] == rd_ptr_r[FIFO_LOG2-1:0]);
  assign sample_s     = (state_r == ST_SCAN) && in_valid;
  assign start_s      = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign pop_s        = !fifo_empty_s && rpt_ready;
  assign push_req_s   = sample_s && !match;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_s       = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s       = push_req_s && fifo_full_s && !pop_s;
  assign head_s       = mem_r[rd_ptr_r[FIFO_LOG2-1:0]];

  // Next-state decode for the sweep sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_next_s = ST_SCAN;
        else       state_next_s = state_r;
      end
      ST_SCAN: begin
        if (sample_s && (addr == ADDR_LAST)) state_next_s = ST_DRAIN;
        else                                 state_next_s = ST_SCAN;
      end
      ST_DRAIN: begin
        if (fifo_empty_s) state_next_s = ST_DONE;
        else              state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state, sweep bookkeeping, status flags and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      expected_r  <= {ADDR_W{1'b0}};
      err_count_r <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      seq_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wr_ptr_r    <= {(FIFO_LOG2+1){1'b0}};
      rd_ptr_r    <= {(FIFO_LOG2+1){1'b0}};
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_SCAN) || (state_next_s == ST_DRAIN);
      done_r  <= (state_next_s == ST_DONE);
      if (start_s) begin
        expected_r  <= {ADDR_W{1'b0}};
        err_count_r <= {CNT_W{1'b0}};
        overflow_r  <= 1'b0;
        seq_err_r   <= 1'b0;
      end else if (sample_s) begin
        // In or out of sequence, the next expected address follows the one just seen.
        expected_r <= addr + ADDR_ONE;
        if (addr != expected_r) seq_err_r <= 1'b1;
        if (!match && (err_count_r != CNT_MAX)) err_count_r <= err_count_r + CNT_ONE;
        if (drop_s) overflow_r <= 1'b1;
      end
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Error FIFO storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[FIFO_LOG2-1:0]] <= {addr, data};
  end

`ifdef PARITY_RECHECK_EN
  logic fault_r;
  logic recheck_bad_s;
  assign recheck_bad_s = ((xor_reduce(data) == parity) != match);

  // Sticky disagreement between the local parity recheck and the upstream match flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_r <= 1'b0;
    end else if (start_s) begin
      fault_r <= 1'b0;
    end else if (sample_s && recheck_bad_s) begin
      fault_r <= 1'b1;
    end
  end
  assign checker_fault = fault_r;
`else
  logic unused_parity_s;
  assign unused_parity_s = parity;
  assign checker_fault   = 1'b0;
`endif

  // Report port driven from the FIFO head; zero while empty.
  always_comb begin
    rpt_valid = !fifo_empty_s;
    if (fifo_empty_s) begin
      rpt_addr = {ADDR_W{1'b0}};
      rpt_data = {DATA_W{1'b0}};
    end else begin
      rpt_addr = head_s[ENT_W-1:DATA_W];
      rpt_data = head_s[DATA_W-1:0];
    end
  end

  assign err_count = err_count_r;
  assign overflow  = overflow_r;
  assign seq_err   = seq_err_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_parity_scan_monitor.sv
// Self-checking bench for parity_scan_monitor: queue-based reference model plus directed pins and random sweeps.
module tb_parity_scan_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, in_valid = 1'b0, parity = 1'b0, match = 1'b1, rpt_ready = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] data = 8'd0;
  logic       rpt_valid, overflow, seq_err, busy, done, checker_fault;
  logic [3:0] rpt_addr;
  logic [7:0] rpt_data;
  logic [4:0] err_count;

  parity_scan_monitor dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .addr(addr), .data(data),
    .parity(parity), .match(match), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_addr(rpt_addr), .rpt_data(rpt_data), .err_count(err_count), .overflow(overflow),
    .seq_err(seq_err), .busy(busy), .done(done), .checker_fault(checker_fault)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: sweep phase, error queue and sticky flags
  typedef struct { logic [3:0] a; logic [7:0] d; } ent_t;
  localparam int P_IDLE = 0, P_SCAN = 1, P_DRAIN = 2, P_DONE = 3;
  ent_t mq[$];
  ent_t dut_pops[$];
  int   m_phase = P_IDLE, m_cnt = 0, m_exp = 0;
  bit   m_ovf = 0, m_seq = 0, m_flt = 0;
  int   busy_cycles = 0, rv_cycles = 0;

  always @(posedge clk) begin : model
    int old_size;
    bit pop;
    old_size = mq.size();
    pop = (old_size > 0) && rpt_ready;
    if (!reset) begin
      m_phase = P_IDLE; mq.delete(); m_cnt = 0; m_exp = 0;
      m_ovf = 0; m_seq = 0; m_flt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      case (m_phase)
        P_IDLE, P_DONE: if (start) begin
          m_phase = P_SCAN; m_cnt = 0; m_exp = 0; m_ovf = 0; m_seq = 0; m_flt = 0;
        end
        P_SCAN: if (in_valid) begin
          if (int'(addr) != m_exp) m_seq = 1;
          m_exp = (int'(addr) + 1) % 16;
`ifdef PARITY_RECHECK_EN
          if ((($countones(data) % 2) == int'(parity)) != match) m_flt = 1;
`endif
          if (!match) begin
            m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
            if (old_size < 4 || pop) mq.push_back('{a: addr, d: data});
            else m_ovf = 1;
          end
          if (addr == 4'd15) m_phase = P_DRAIN;
        end
        P_DRAIN: if (old_size == 0) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model, plus pop logging
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rpt_valid", rpt_valid, mq.size() > 0);
      check("rpt_addr", rpt_addr, (mq.size() > 0) ? mq[0].a : 4'd0);
      check("rpt_data", rpt_data, (mq.size() > 0) ? mq[0].d : 8'd0);
      check("err_count", err_count, m_cnt);
      check("overflow", overflow, m_ovf);
      check("seq_err", seq_err, m_seq);
      check("busy", busy, (m_phase == P_SCAN) || (m_phase == P_DRAIN));
      check("done", done, m_phase == P_DONE);
      check("checker_fault", checker_fault, m_flt);
      if (busy) busy_cycles++;
      if (rpt_valid) rv_cycles++;
      if (reset && rpt_valid && rpt_ready) dut_pops.push_back('{a: rpt_addr, d: rpt_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic sample(input logic [3:0] a, input logic [7:0] d, input logic m);
    in_valid = 1'b1; addr = a; data = d; match = m;
    parity = (^d) ^ ~m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin tick(); n++; end
    check("done_timeout", done, 1'b1);
  endtask

  logic [7:0] sd;
  bit         do_rst;
  int         rst_at;

  initial begin
    tick(); cmp_en = 1'b1;
    tick(); reset = 1'b1; tick();
    check("rst_rpt_valid", rpt_valid, 1'b0);
    check("rst_rpt_addr", rpt_addr, 4'd0);
    check("rst_rpt_data", rpt_data, 8'd0);
    check("rst_err_count", err_count, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // 1: clean sweep
    busy_cycles = 0; rv_cycles = 0; rpt_ready = 1'b1;
    pulse_start();
    for (int a = 0; a < 16; a++) begin sd = 8'($urandom); sample(4'(a), sd, 1'b1); end
    wait_done(20);
    check("t1_busy_cycles", busy_cycles, 17);
    check("t1_rv_cycles", rv_cycles, 0);
    check("t1_err_count", err_count, 5'd0);
    check("t1_seq_err", seq_err, 1'b0);
    check("t1_overflow", overflow, 1'b0);

    // 2: two errors popped in order
    dut_pops.delete();
    pulse_start();
    for (int a = 0; a < 16; a++) begin
      sd = (a == 3) ? 8'h35 : (a == 9) ? 8'h9B : 8'($urandom);
      sample(4'(a), sd, !(a == 3 || a == 9));
    end
    wait_done(20);
    check("t2_npops", dut_pops.size(), 2);
    check("t2_pop0", {dut_pops[0].a, dut_pops[0].d}, 12'h335);
    check("t2_pop1", {dut_pops[1].a, dut_pops[1].d}, 12'h99B);
    check("t2_err_count", err_count, 5'd2);

    // 3: overflow with a stalled consumer
    rpt_ready = 1'b0;
    pulse_start();
    for (int a = 0; a < 16; a++) begin sd = 8'($urandom); sample(4'(a), sd, a > 5); end
    repeat (5) tick();
    check("t3_busy", busy, 1'b1);
    check("t3_done", done, 1'b0);
    check("t3_err_count", err_count, 5'd6);
    check("t3_overflow", overflow, 1'b1);
    check("t3_head_addr", rpt_addr, 4'd0);
    dut_pops.delete();
    rpt_ready = 1'b1;
    wait_done(20);
    check("t3_npops", dut_pops.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_pop_addr", dut_pops[i].a, i);

    // 4: skipped address
    pulse_start();
    for (int a = 0; a < 16; a++) begin
      if (a != 5) begin
        sd = 8'($urandom); sample(4'(a), sd, 1'b1);
        if (a == 4) check("t4_seq_before", seq_err, 1'b0);
        if (a == 6) check("t4_seq_after", seq_err, 1'b1);
      end
    end
    wait_done(20);
    check("t4_seq_final", seq_err, 1'b1);

    // 5: reset in the middle of a scan
    rpt_ready = 1'b0;
    pulse_start();
    for (int a = 0; a < 7; a++) begin sd = 8'($urandom); sample(4'(a), sd, !(a == 1 || a == 2)); end
    in_valid = 1'b1; addr = 4'd7; reset = 1'b0; tick(); in_valid = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_err_count", err_count, 5'd0);
    check("t5_rpt_valid", rpt_valid, 1'b0);
    reset = 1'b1; tick();
    pulse_start();
    check("t5_restart_busy", busy, 1'b1);
    rpt_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin sd = 8'($urandom); sample(4'(a), sd, 1'b1); end
    wait_done(20);

    // 6: recheck disagreement
    pulse_start();
    in_valid = 1'b1; addr = 4'd0; data = 8'h01; parity = 1'b1; match = 1'b0; tick(); in_valid = 1'b0;
`ifdef PARITY_RECHECK_EN
    check("t6_checker_fault", checker_fault, 1'b1);
`else
    check("t6_checker_fault", checker_fault, 1'b0);
`endif
    check("t6_err_count", err_count, 5'd1);
    for (int a = 1; a < 16; a++) begin sd = 8'($urandom); sample(4'(a), sd, 1'b1); end
    wait_done(20);

    // 7: error counter saturation with a stuck address
    pulse_start();
    for (int i = 0; i < 40; i++) begin sd = 8'($urandom); sample(4'd0, sd, 1'b0); end
    sample(4'd15, 8'h00, 1'b1);
    check("t7_err_sat", err_count, 5'd31);
    check("t7_seq_err", seq_err, 1'b1);
    wait_done(20);

    // Random sweeps
    for (int r = 0; r < 40; r++) begin
      do_rst = ($urandom_range(0, 4) == 0);
      rst_at = $urandom_range(0, 15);
      pulse_start();
      for (int a = 0; a < 16; a++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; rpt_ready = 1'($urandom_range(0, 1));
          start = ($urandom_range(0, 9) == 0); tick();
        end
        start = 1'b0;
        if (do_rst && a == rst_at) begin
          reset = 1'b0; in_valid = 1'($urandom_range(0, 1)); tick();
          reset = 1'b1; in_valid = 1'b0;
          break;
        end
        in_valid = 1'b1;
        addr = (a == 15) ? 4'd15 : (($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(a));
        data = 8'($urandom);
        match = ($urandom_range(0, 2) != 0);
        parity = (^data) ^ ~match ^ ($urandom_range(0, 15) == 0);
        rpt_ready = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid = 1'b0; start = 1'b0;
      if (!do_rst) begin rpt_ready = 1'b1; wait_done(40); end
      else tick();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
